// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcode values, FSM state
// encoding and a small opcode classification helper.
package alu_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ADD and SUB are the only operations that propagate a carry
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice. SUB is computed as a + ~b + cin, so the
// caller seeds cin with 1 for the first bit of a subtraction. Logic and
// reserved opcodes never generate a carry.
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] opcode,
    output logic       res_bit,
    output logic       cout
);

    logic b_eff;

    assign b_eff = (opcode == OP_SUB) ? ~b : b;

    // Per-bit operation select; defaults cover the reserved opcodes
    always_comb begin
        res_bit = 1'b0;
        cout    = 1'b0;
        case (opcode)
            OP_NOT: res_bit = ~a;
            OP_AND: res_bit = a & b;
            OP_XOR: res_bit = a ^ b;
            OP_ADD, OP_SUB: begin
                res_bit = a ^ b_eff ^ cin;
                cout    = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_bitserial.sv
// Bit-serial ALU: WIDTH-bit operands processed LSB-first through one
// alu_slice with a registered carry. Operands and results move over
// valid/ready handshakes; the result appears WIDTH edges after acceptance.
// Optional macro ALU_BITSERIAL_FLAGS_EN enables zero_flag and ovf_flag;
// without it both ports are tied low.
module alu_bitserial
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             zero_flag,
    output logic             ovf_flag
);

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, result_r;
    logic [2:0]       op_r;
    logic             carry_r, carry_out_r;
    logic [CNT_W-1:0] cnt;
    logic             slice_bit, slice_cout;
    logic             last_step;
    logic [WIDTH-1:0] res_next;

    alu_slice u_slice (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .cin     (carry_r),
        .opcode  (op_r),
        .res_bit (slice_bit),
        .cout    (slice_cout)
    );

    assign res_next  = {slice_bit, res_sh[WIDTH-1:1]};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (last_step) next_state = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand latch, serial shifting and result capture on the MSB step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            op_r        <= OP_NOT;
            carry_r     <= 1'b0;
            cnt         <= '0;
            result_r    <= '0;
            carry_out_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        op_r    <= opcode;
                        carry_r <= (opcode == OP_SUB);
                        cnt     <= '0;
                    end
                end
                ST_BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    if (is_arith(op_r)) carry_r <= slice_cout;
                    if (last_step) begin
                        result_r    <= res_next;
                        carry_out_r <= slice_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_r;
    assign carry_out = carry_out_r;

`ifdef ALU_BITSERIAL_FLAGS_EN
    logic zero_r, ovf_r;

    // Flag capture on the MSB step; carry_r still holds the MSB carry-in here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == ST_BUSY && last_step) begin
            zero_r <= (res_next == '0);
            ovf_r  <= is_arith(op_r) & (carry_r ^ slice_cout);
        end
    end

    assign zero_flag = zero_r;
    assign ovf_flag  = ovf_r;
`else
    assign zero_flag = 1'b0;
    assign ovf_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bitserial.sv
// Self-checking bench for alu_bitserial (WIDTH=8): directed cases plus
// randomized operations compared against an integer-arithmetic model.
module tb_alu_bitserial;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in, b_in;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out, busy, zero_flag, ovf_flag;

    int checks = 0;
    int errors = 0;

    alu_bitserial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy),
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model written with plain integer arithmetic
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  output logic [7:0] r, output logic c, output logic z, output logic v);
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r = 8'(255 - ua);
            3'd1: r = a & b;
            3'd2: r = a ^ b;
            3'd3: begin
                r = 8'((ua + ub) % 256);
                c = (ua + ub) > 255;
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            3'd4: begin
                r = 8'((ua - ub + 256) % 256);
                c = ua >= ub;
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            default: ;
        endcase
`ifdef ALU_BITSERIAL_FLAGS_EN
        z = (r == 8'h00);
`else
        z = 1'b0;
        v = 1'b0;
`endif
    endfunction

    // One full transaction: issue, wait for result, optional back-pressure, retire
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input int hold);
        logic [7:0] er;
        logic       ec, ez, ev;
        int         edges;
        logic [7:0] held;
        model(a, b, op, er, ec, ez, ev);
        @(negedge clk);
        checkOutput("in_ready idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        opcode    = op;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput($sformatf("latency op%0d", op), 64'(edges), 64'(WIDTH));
        checkOutput($sformatf("result op%0d %0h,%0h", op, a, b), 64'(result), 64'(er));
        checkOutput($sformatf("carry op%0d %0h,%0h", op, a, b), 64'(carry_out), 64'(ec));
        checkOutput($sformatf("zero op%0d %0h,%0h", op, a, b), 64'(zero_flag), 64'(ez));
        checkOutput($sformatf("ovf op%0d %0h,%0h", op, a, b), 64'(ovf_flag), 64'(ev));
        checkOutput("busy in done", 64'(busy), 64'd1);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            @(posedge clk);
            #1;
            checkOutput("held out_valid", 64'(out_valid), 64'd1);
            checkOutput("held result", 64'(result), 64'(held));
            checkOutput("held in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("out_valid drop", 64'(out_valid), 64'd0);
        checkOutput("busy drop", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        opcode    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset carry", 64'(carry_out), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hFF, 8'h01, OP_ADD, 0);
        applyStimulus(8'h05, 8'h07, OP_SUB, 0);
        applyStimulus(8'h07, 8'h05, OP_SUB, 0);
        applyStimulus(8'h7F, 8'h01, OP_ADD, 0);
        applyStimulus(8'h80, 8'h01, OP_SUB, 0);
        applyStimulus(8'hA5, 8'h00, OP_NOT, 0);
        applyStimulus(8'hF0, 8'h3C, OP_AND, 0);
        applyStimulus(8'hF0, 8'h3C, OP_XOR, 0);
        applyStimulus(8'hF0, 8'h3C, 3'b111, 0);
        applyStimulus(8'h3C, 8'h3C, OP_SUB, 5);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        // Abort mid-operation: reset at bit 4 must clear a previously presented result
        applyStimulus(8'h33, 8'h11, OP_ADD, 0);
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 8'hFF;
        b_in     = 8'hFF;
        opcode   = OP_ADD;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort result", 64'(result), 64'd0);
        checkOutput("abort carry", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h12, 8'h34, OP_ADD, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
